// File: rtl/gb_host_bridge.sv
// gb_host_bridge: turns valid/ready host requests into one-cycle ghostbus strobes and returns one response each.
// Optional strobe counters (stat_wr_cnt/stat_rd_cnt/stat_clr) are built when GB_HOST_BRIDGE_STATS_EN is defined.
module gb_host_bridge #(
  parameter int AW = 24,
  parameter int DW = 32,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_we,
  output logic [DW-1:0] rsp_rdata,
  output logic [AW-1:0] gb_addr,
  output logic [DW-1:0] gb_wdata,
  output logic          gb_we,
  output logic          gb_re,
`ifdef GB_HOST_BRIDGE_STATS_EN
  input  logic          stat_clr,
  output logic [15:0]   stat_wr_cnt,
  output logic [15:0]   stat_rd_cnt,
`endif
  input  logic [DW-1:0] gb_rdata
);
  if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_lat
    $error("gb_host_bridge: RD_LAT must be 1..15");
  end
  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, RESP} state_t;
  state_t state, state_nx;
  logic we_q;
  logic [3:0] cnt;
  logic accept;
  assign accept = req_valid && req_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = accept ? ISSUE : IDLE;
      ISSUE: state_nx = we_q ? RESP : RWAIT;
      RWAIT: state_nx = (cnt == 4'd0) ? RESP : RWAIT;
      RESP:  state_nx = rsp_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  // req_ready is held low while reset is asserted so nothing is offered to the host
  always_comb begin
    req_ready = rst_n && (state == IDLE);
    rsp_valid = (state == RESP);
    rsp_we = (state == RESP) && we_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gb_we <= 1'b0;
      gb_re <= 1'b0;
      gb_addr <= '0;
      gb_wdata <= '0;
      we_q <= 1'b0;
      cnt <= 4'd0;
      rsp_rdata <= '0;
    end else begin
      gb_we <= accept && req_we;
      gb_re <= accept && !req_we;
      if (accept) begin
        gb_addr <= req_addr;
        gb_wdata <= req_wdata;
        we_q <= req_we;
      end
      if (state == ISSUE) begin
        cnt <= 4'(RD_LAT - 1);
        if (we_q) rsp_rdata <= '0;
      end
      if (state == RWAIT) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd0) rsp_rdata <= gb_rdata;
      end
    end
`ifdef GB_HOST_BRIDGE_STATS_EN
  // clear has priority over a coincident strobe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_wr_cnt <= 16'd0;
      stat_rd_cnt <= 16'd0;
    end else begin
      stat_wr_cnt <= stat_clr ? 16'd0 : stat_wr_cnt + 16'(gb_we);
      stat_rd_cnt <= stat_clr ? 16'd0 : stat_rd_cnt + 16'(gb_re);
    end
`endif
endmodule

// File: tb/tb_gb_host_bridge.sv
// tb_gb_host_bridge: directed checks of gb_host_bridge at RD_LAT = 2 (main), 1 and 15.
module tb_gb_host_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic req_valid [3];
  logic req_ready [3];
  logic req_we [3];
  logic rsp_valid [3];
  logic rsp_ready [3];
  logic rsp_we [3];
  logic gb_we [3];
  logic gb_re [3];
  logic [23:0] req_addr [3];
  logic [23:0] gb_addr [3];
  logic [31:0] req_wdata [3];
  logic [31:0] rsp_rdata [3];
  logic [31:0] gb_wdata [3];
  logic [31:0] gb_rdata [3];
  logic [31:0] rd_val [3];
`ifdef GB_HOST_BRIDGE_STATS_EN
  logic stat_clr [3];
  logic [15:0] stat_wr_cnt [3];
  logic [15:0] stat_rd_cnt [3];
`endif
  int checks = 0;
  int errors = 0;

  for (genvar i = 0; i < 3; i++) begin : g
    localparam int L = (i == 0) ? 2 : (i == 1) ? 1 : 15;
    logic [7:0] since;
    gb_host_bridge #(.AW(24), .DW(32), .RD_LAT(L)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[i]), .req_ready(req_ready[i]), .req_we(req_we[i]),
      .req_addr(req_addr[i]), .req_wdata(req_wdata[i]),
      .rsp_valid(rsp_valid[i]), .rsp_ready(rsp_ready[i]), .rsp_we(rsp_we[i]),
      .rsp_rdata(rsp_rdata[i]), .gb_addr(gb_addr[i]), .gb_wdata(gb_wdata[i]),
      .gb_we(gb_we[i]), .gb_re(gb_re[i]),
`ifdef GB_HOST_BRIDGE_STATS_EN
      .stat_clr(stat_clr[i]), .stat_wr_cnt(stat_wr_cnt[i]), .stat_rd_cnt(stat_rd_cnt[i]),
`endif
      .gb_rdata(gb_rdata[i])
    );
    // read data is valid only in the cycle exactly L cycles after the gb_re cycle
    always @(posedge clk or negedge rst_n)
      if (!rst_n) since <= 8'd0;
      else if (gb_re[i]) since <= 8'd1;
      else if (since != 8'd0 && since != 8'hff) since <= since + 8'd1;
    assign gb_rdata[i] = (since == 8'(L)) ? rd_val[i] : 32'hDEADBEEF;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input int k, input logic we, input logic [23:0] a, input logic [31:0] d,
                     input logic [31:0] exp, input int lat, input string nm);
    int n, nw, nr;
    logic [23:0] sa;
    logic [31:0] sd;
    nw = 0; nr = 0; sa = '0; sd = '0;
    req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = a; req_wdata[k] = d; rsp_ready[k] = 1'b1;
    checks++;
    if (req_ready[k] !== 1'b1) begin errors++; $display("FAIL %s req_ready got %b want 1", nm, req_ready[k]); end
    tick();
    req_valid[k] = 1'b0; req_addr[k] = ~a; req_wdata[k] = ~d;
    n = 1;
    while (rsp_valid[k] !== 1'b1 && n < 40) begin
      checks++;
      if (gb_we[k] === 1'b1 && gb_re[k] === 1'b1) begin errors++; $display("FAIL %s both strobes high at cycle %0d", nm, n); end
      if (gb_we[k] === 1'b1) begin nw++; sa = gb_addr[k]; sd = gb_wdata[k]; end
      if (gb_re[k] === 1'b1) begin nr++; sa = gb_addr[k]; end
      tick();
      n++;
    end
    checks++;
    if (n != lat) begin errors++; $display("FAIL %s latency got %0d want %0d", nm, n, lat); end
    checks++;
    if (nw != int'(we) || nr != int'(!we)) begin errors++; $display("FAIL %s strobes got we=%0d re=%0d want we=%0d re=%0d", nm, nw, nr, we, !we); end
    checks++;
    if (sa !== a) begin errors++; $display("FAIL %s gb_addr got %h want %h", nm, sa, a); end
    if (we) begin
      checks++;
      if (sd !== d) begin errors++; $display("FAIL %s gb_wdata got %h want %h", nm, sd, d); end
    end
    checks++;
    if (rsp_we[k] !== we || rsp_rdata[k] !== exp) begin errors++; $display("FAIL %s rsp got we=%b data=%h want we=%b data=%h", nm, rsp_we[k], rsp_rdata[k], we, exp); end
    tick();
    checks++;
    if (rsp_valid[k] !== 1'b0 || req_ready[k] !== 1'b1) begin errors++; $display("FAIL %s after handshake rsp_valid=%b req_ready=%b want 0/1", nm, rsp_valid[k], req_ready[k]); end
  endtask

  task automatic check_idle_zero(input string nm, input logic want_ready);
    checks++;
    if (gb_we[0] !== 1'b0 || gb_re[0] !== 1'b0 || rsp_valid[0] !== 1'b0 || rsp_we[0] !== 1'b0 ||
        rsp_rdata[0] !== 32'h0 || gb_addr[0] !== 24'h0 || gb_wdata[0] !== 32'h0)
    begin
      errors++;
      $display("FAIL %s outputs we=%b re=%b rv=%b rwe=%b rd=%h a=%h wd=%h want all 0", nm,
               gb_we[0], gb_re[0], rsp_valid[0], rsp_we[0], rsp_rdata[0], gb_addr[0], gb_wdata[0]);
    end
    if (want_ready) begin
      checks++;
      if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL %s req_ready got %b want 1", nm, req_ready[0]); end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    check_idle_zero("reset_asserted", 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_idle_zero("reset_released", 1'b1);
  endtask

  task automatic test_write();
    txn(0, 1'b1, 24'h000040, 32'h0000000A, 32'h0, 2, "write_basic");
  endtask

  task automatic test_read_latency();
    rd_val[0] = 32'h00000042;
    rd_val[1] = 32'h00000042;
    rd_val[2] = 32'h00000042;
    txn(0, 1'b0, 24'h000010, 32'h0, 32'h00000042, 4, "read_lat2");
    txn(1, 1'b0, 24'h000010, 32'h0, 32'h00000042, 3, "read_lat1");
    txn(2, 1'b0, 24'h000010, 32'h0, 32'h00000042, 17, "read_lat15");
  endtask

  task automatic test_stall();
    int n;
    rd_val[0] = 32'h00000077;
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 24'h000020; rsp_ready[0] = 1'b0;
    tick();
    req_valid[0] = 1'b0;
    n = 0;
    while (rsp_valid[0] !== 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if (rsp_valid[0] !== 1'b1) begin errors++; $display("FAIL stall_wait rsp_valid got %b want 1", rsp_valid[0]); end
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 24'h000099; req_wdata[0] = 32'h55;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (req_ready[0] !== 1'b0 || gb_we[0] !== 1'b0 || gb_re[0] !== 1'b0 || rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'h77) begin
        errors++;
        $display("FAIL stall_cycle%0d rdy=%b we=%b re=%b rv=%b rd=%h want 0/0/0/1/00000077", c,
                 req_ready[0], gb_we[0], gb_re[0], rsp_valid[0], rsp_rdata[0]);
      end
      tick();
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    tick();
    checks++;
    if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1 || gb_addr[0] !== 24'h000020) begin
      errors++;
      $display("FAIL stall_release rv=%b rdy=%b addr=%h want 0/1/000020", rsp_valid[0], req_ready[0], gb_addr[0]);
    end
    txn(0, 1'b1, 24'h000099, 32'h00000055, 32'h0, 2, "after_stall_write");
  endtask

  task automatic test_reset_mid();
    rd_val[0] = 32'h00000011;
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 24'h000030; rsp_ready[0] = 1'b1;
    tick();
    req_valid[0] = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check_idle_zero("reset_mid_rwait", 1'b0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (rsp_valid[0] !== 1'b0 || gb_re[0] !== 1'b0) begin errors++; $display("FAIL reset_mid_norsp cycle%0d rv=%b re=%b want 0/0", c, rsp_valid[0], gb_re[0]); end
    end
    txn(0, 1'b1, 24'h000044, 32'h12345678, 32'h0, 2, "reset_mid_next_write");
  endtask

  task automatic test_back_to_back();
    rd_val[0] = 32'hA5A50001;
    txn(0, 1'b1, 24'h000100, 32'h00000001, 32'h0, 2, "b2b_w0");
    txn(0, 1'b1, 24'h000104, 32'h00000002, 32'h0, 2, "b2b_w1");
    txn(0, 1'b1, 24'h000108, 32'h00000003, 32'h0, 2, "b2b_w2");
    txn(0, 1'b0, 24'h000200, 32'h0, 32'hA5A50001, 4, "b2b_r0");
    rd_val[0] = 32'hA5A50002;
    txn(0, 1'b0, 24'h000204, 32'h0, 32'hA5A50002, 4, "b2b_r1");
  endtask

`ifdef GB_HOST_BRIDGE_STATS_EN
  task automatic test_stats();
    stat_clr[0] = 1'b1;
    tick();
    stat_clr[0] = 1'b0;
    rd_val[0] = 32'h0;
    txn(0, 1'b1, 24'h000001, 32'h1, 32'h0, 2, "stats_w0");
    txn(0, 1'b1, 24'h000002, 32'h2, 32'h0, 2, "stats_w1");
    txn(0, 1'b1, 24'h000003, 32'h3, 32'h0, 2, "stats_w2");
    txn(0, 1'b0, 24'h000004, 32'h0, 32'h0, 4, "stats_r0");
    txn(0, 1'b0, 24'h000005, 32'h0, 32'h0, 4, "stats_r1");
    checks++;
    if (stat_wr_cnt[0] !== 16'd3 || stat_rd_cnt[0] !== 16'd2) begin errors++; $display("FAIL stats_count wr=%0d rd=%0d want 3/2", stat_wr_cnt[0], stat_rd_cnt[0]); end
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 24'h000006; req_wdata[0] = 32'h6; rsp_ready[0] = 1'b1;
    tick();
    req_valid[0] = 1'b0;
    stat_clr[0] = 1'b1;
    checks++;
    if (gb_we[0] !== 1'b1) begin errors++; $display("FAIL stats_clr_strobe gb_we got %b want 1", gb_we[0]); end
    tick();
    stat_clr[0] = 1'b0;
    checks++;
    if (stat_wr_cnt[0] !== 16'd0 || stat_rd_cnt[0] !== 16'd0) begin errors++; $display("FAIL stats_clr wr=%0d rd=%0d want 0/0", stat_wr_cnt[0], stat_rd_cnt[0]); end
    tick();
  endtask
`endif

  initial begin
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0; req_wdata[k] = '0;
      rsp_ready[k] = 1'b1; rd_val[k] = '0;
`ifdef GB_HOST_BRIDGE_STATS_EN
      stat_clr[k] = 1'b0;
`endif
    end
    test_reset();
    test_write();
    test_read_latency();
    test_stall();
    test_reset_mid();
    test_back_to_back();
`ifdef GB_HOST_BRIDGE_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gb_host_bridge.md
Name: gb_host_bridge

Overview:
- Upstream host-side stage feeding the ghostbus port bundle of a decoded module tree, e.g. the `GHOSTBUSPORTS` of a top instance containing submod_foo.
- Converts a valid/ready request stream (one read or write per request) into single-cycle ghostbus strobes.
- Waits the fixed ghostbus read latency, then captures read data.
- Returns one response per request on a valid/ready response stream.
- One transaction in flight at a time; no reordering.

Parameters:
- AW, 24: ghostbus address width.
- DW, 32: ghostbus data width.
- RD_LAT, 2: cycles from the gb_re pulse cycle to the cycle in which gb_rdata is valid; legal range 1..15.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  host request valid.
- req_ready  output  1  bridge can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  AW  target address.
- req_wdata  input  DW  write data; ignored for reads.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  host accepts response.
- rsp_we  output  1  echo of req_we for this response.
- rsp_rdata  output  DW  captured read data; 0 for write responses.
- gb_addr  output  AW  ghostbus address.
- gb_wdata  output  DW  ghostbus write data.
- gb_we  output  1  ghostbus write strobe, one cycle.
- gb_re  output  1  ghostbus read strobe, one cycle.
- gb_rdata  input  DW  ghostbus read data.

Behaviour:
- Reset (async assert, sync deassert by design): state IDLE; req_ready=1 once out of reset; rsp_valid=0, rsp_we=0, rsp_rdata=0, gb_addr=0, gb_wdata=0, gb_we=0, gb_re=0, latency counter=0.
- States: IDLE, ISSUE, RWAIT, RESP.
- IDLE:
  - req_ready=1 combinationally from state, only in IDLE.
  - On req_valid&&req_ready, register req_addr→gb_addr, req_wdata→gb_wdata, req_we→stored we; go to ISSUE.
- ISSUE (exactly one cycle):
  - gb_we=stored we, gb_re=!stored we; both registered outputs, so active in the first cycle after acceptance.
  - Write: next state RESP, rsp_rdata←0.
  - Read: load counter with RD_LAT-1; next state RWAIT.
- RWAIT:
  - Decrement counter each cycle.
  - When counter==0, sample gb_rdata into rsp_rdata; go to RESP.
  - Sampling edge is the end of the cycle exactly RD_LAT cycles after the gb_re cycle. With RD_LAT=1, RWAIT lasts one cycle.
- RESP:
  - rsp_valid=1, rsp_we=stored we.
  - rsp_rdata stable until handshake.
  - On rsp_valid&&rsp_ready, return to IDLE; rsp_valid drops the next cycle.
- Latency:
  - Write: accept edge → rsp_valid 2 cycles later.
  - Read: accept edge → rsp_valid RD_LAT+2 cycles later.
  - Minimum back-to-back write period 3 cycles with rsp_ready held high.
- gb_we and gb_re are never both high and are never high outside ISSUE.
- gb_addr/gb_wdata hold their last value between transactions; they change only on acceptance.
- req_valid while not IDLE: ignored and not accepted; request inputs may change freely.
- rsp_ready low in RESP: stall indefinitely, no new strobes issued.
- Reset mid-transaction (any state): the transaction is dropped, a pending strobe is cancelled immediately, and no response is produced.

Optional Feature:
- Macro: GB_HOST_BRIDGE_STATS_EN.
- When defined, adds outputs stat_wr_cnt[15:0] and stat_rd_cnt[15:0].
  - Each increments by 1 on the cycle gb_we (resp. gb_re) is asserted.
  - Wraps 0xFFFF→0x0000; reset to 0.
  - Also adds input stat_clr: synchronous clear of both counters. If a strobe coincides with stat_clr, the clear wins and the count is 0.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then write addr=0x000040 data=0x0000000A, rsp_ready=1 → gb_we high for exactly 1 cycle with gb_addr=0x40, gb_wdata=0xA; rsp_valid 2 cycles after acceptance; rsp_we=1, rsp_rdata=0.
- Read addr=0x000010, RD_LAT=2, model returns 0x00000042 only in the cycle 2 after gb_re (other cycles 0xDEADBEEF) → rsp_rdata=0x42, rsp_valid 4 cycles after acceptance; repeat with RD_LAT=1 and RD_LAT=15.
- Hold rsp_ready=0 for 10 cycles after a read completes with req_valid=1 → req_ready=0 throughout; no gb_we/gb_re; rsp_rdata stable; handshake then returns to IDLE and the next request is accepted.
- Deassert rst_n during RWAIT of a read → all outputs 0 immediately; no rsp_valid after release; the next write completes normally.
- Stream 3 writes then 2 reads with rsp_ready=1 → strobes in order; gb_we/gb_re never simultaneously high; 5 responses in order.
- With GB_HOST_BRIDGE_STATS_EN: 3 writes and 2 reads → stat_wr_cnt=3, stat_rd_cnt=2; assert stat_clr coincident with a gb_we pulse → both counts 0.
